// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - Shared encodings for the multicycle RV32I control unit
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE: imm_src_of = IMM_S;
            OP_BEQ:   imm_src_of = IMM_B;
            OP_JAL:   imm_src_of = IMM_J;
            default:  imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - ALUOp/funct3/funct7b5/op5 to ALUControl decoder
// Ports: alu_op, funct3, funct7b5, op5 in; alu_control out (combinational).
module alu_decoder
    import mcu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) distinguishes sub; addi ignores funct7b5.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Multicycle RV32I control FSM with instret counter
// Ports: clk, rst_n (sync active-low), op/funct3/funct7b5 from IR, zero, mem_ready in;
//        datapath enables/selects, ALUControl, instret, illegal out.
// Option: ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       immSrc,
    output logic [2:0]       ALUControl,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    state_t     state, next;
    logic       ready;
    logic [1:0] alu_op;
    logic       pc_write, mem_write, ir_write, reg_write;

    assign ready = MEM_WAIT ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next;
            if (state == S_MEMWB || state == S_ALUWB || state == S_BEQ ||
                (state == S_MEMWRITE && ready))
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        next      = state;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next = S_MEMADR;
                    OP_RTYPE:          next = S_EXECR;
                    OP_ITYPE:          next = S_EXECI;
                    OP_JAL:            next = S_JAL;
                    OP_BEQ:            next = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:           next = S_TRAP;
`else
                    default:           next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                // op[5] separates store (0100011) from load (0000011).
                next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (ready) next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
                next    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                next     = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_RS1;
                alu_op   = ALUOP_SUB;
                pc_write = zero;
                next     = S_FETCH;
            end
            S_TRAP:  next = S_TRAP;
            default: next = S_FETCH;
        endcase
    end

    // Enables are gated by reset so an in-flight write drops in the reset cycle.
    assign PCWrite  = pc_write  & rst_n;
    assign MemWrite = mem_write & rst_n;
    assign IRWrite  = ir_write  & rst_n;
    assign RegWrite = reg_write & rst_n;
    assign immSrc   = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (next == S_TRAP)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule
